rc5_key_schedule: RTL

Parametrised RC5 key-expansion engine. It takes a B-byte secret key and the magic constants, packs the key bytes into C words of W bits (the L array), initialises the T-word S table from P and Q, and runs the 3·max(T,C) mixing pass. Once `done` is pulsed, the encrypt/decrypt datapath reads the finished S table through a registered read port.

---
 rtl/rc5_key_schedule.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rc5_key_schedule.sv
// RC5 key expansion: packs the key into L, fills S from P/Q, then runs 3*max(T,C) mix steps.
// done fires 1+T+N cycles after the start edge; start is ignored unless IDLE; s_data has 1-cycle latency.
module rc5_key_schedule #(
    parameter int W = 32,
    parameter int B = 16,
    parameter int R = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [8*B-1:0]               key,
    input  logic [W-1:0]                 pW,
    input  logic [W-1:0]                 qW,
    output logic                         busy,
    output logic                         done,
    input  logic [$clog2(2*R+2)-1:0]     s_addr,
    output logic [W-1:0]                 s_data
);

    localparam int T  = 2 * R + 2;
    localparam int U  = W / 8;
    localparam int CR = (B + U - 1) / U;
    localparam int C  = (CR < 1) ? 1 : CR;
    localparam int N  = 3 * ((T > C) ? T : C);
    localparam int AW = $clog2(T);
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int NW = $clog2(N);
    localparam int LW = $clog2(W);

    typedef enum logic [2:0] {IDLE, LOAD, INIT, MIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   s_q [T];
    logic [W-1:0]   l_q [C];
    logic [W-1:0]   a_q, b_q, p_q, q_q, run_q, s_data_q;
    logic [AW-1:0]  i_q;
    logic [CW-1:0]  j_q;
    logic [NW-1:0]  cnt_q;
    logic [C*W-1:0] key_pad;
    logic [W-1:0]   a_new, ab_sum, b_new;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    always_comb begin
        key_pad            = '0;
        key_pad[8*B-1:0]   = key;
    end

    // One mix step: S-side rotate by 3, then L-side data-dependent rotate.
    always_comb begin
        a_new  = rotl(s_q[i_q] + a_q + b_q, LW'(3));
        ab_sum = a_new + b_q;
        b_new  = rotl(l_q[j_q] + ab_sum, ab_sum[LW-1:0]);
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                busy    = 1'b1;
                state_d = INIT;
            end
            INIT: begin
                busy = 1'b1;
                if (i_q == AW'(T - 1)) state_d = MIX;
            end
            MIX: begin
                busy = 1'b1;
                if (cnt_q == NW'(N - 1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < T; k++) s_q[k] <= '0;
            for (int k = 0; k < C; k++) l_q[k] <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            q_q      <= '0;
            run_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            cnt_q    <= '0;
            s_data_q <= '0;
        end else begin
            s_data_q <= ({1'b0, s_addr} < (AW + 1)'(T)) ? s_q[s_addr] : '0;
            case (state_q)
                IDLE: if (start) begin
                    // Key is packed straight into L on capture; no separate key register needed.
                    p_q <= pW;
                    q_q <= qW;
                    for (int k = 0; k < C; k++) l_q[k] <= key_pad[k*W +: W];
                end
                LOAD: begin
                    a_q   <= '0;
                    b_q   <= '0;
                    i_q   <= '0;
                    j_q   <= '0;
                    cnt_q <= '0;
                    run_q <= p_q;
                end
                INIT: begin
                    s_q[i_q] <= run_q;
                    run_q    <= run_q + q_q;
                    i_q      <= (i_q == AW'(T - 1)) ? '0 : i_q + AW'(1);
                end
                MIX: begin
                    s_q[i_q] <= a_new;
                    l_q[j_q] <= b_new;
                    a_q      <= a_new;
                    b_q      <= b_new;
                    i_q      <= (i_q == AW'(T - 1)) ? '0 : i_q + AW'(1);
                    j_q      <= (j_q == CW'(C - 1)) ? '0 : j_q + CW'(1);
                    cnt_q    <= cnt_q + NW'(1);
                end
                default: ;
            endcase
        end
    end

    assign s_data = s_data_q;

endmodule
